// File: rtl/scale_controller.sv
// scale_controller: debounced pushbutton front end that owns the divider's
//   scale value and issues a registered active-low reload pulse on change.
// Latency: a press first sampled at edge 0 yields its event at edge
//   2+DEBOUNCE_CYCLES; scale updates and div_nrst falls at edge 3+DEBOUNCE_CYCLES.
// Backpressure: none upstream; button events that arrive while a reload is in
//   progress are dropped, not queued (busy flags that window).
//
// Ports:
//   clk_in    in   1      system clock, rising edge
//   nrst      in   1      asynchronous active-low reset
//   btn_up    in   1      raw button, increments scale on press
//   btn_down  in   1      raw button, decrements scale on press
//   btn_load  in   1      raw button, loads load_val on press
//   load_val  in   WIDTH  quasi-static load value, sampled on a load event
//   scale     out  WIDTH  registered scale for the divider
//   div_nrst  out  1      registered divider reset, low during a reload
//   busy      out  1      registered, always the complement of div_nrst
//
// Build option: define SCALE_WRAP_EN to make up/down wrap modulo 2^WIDTH
// instead of saturating (default: saturate, no reload when pinned).

// One button path: 2-flop synchroniser, debouncer, registered rising-edge event.
module scale_btn_path #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic raw,
  output logic press
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic          stable_d;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // The stable level only moves after DEBOUNCE_CYCLES consecutive cycles of
  // disagreement; a single agreeing cycle restarts the count.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // Registered so the event is a clean single-cycle pulse one edge after the
  // stable level rises; releases never generate an event.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

module scale_controller #(
  parameter int              WIDTH           = 8,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              RELOAD_LEN      = 4,
  parameter logic [WIDTH-1:0] SCALE_INIT     = '0
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] scale,
  output logic             div_nrst,
  output logic             busy
);

  localparam int RW = (RELOAD_LEN > 1) ? $clog2(RELOAD_LEN) : 1;
  localparam logic [RW-1:0]    RL_LAST  = RW'(RELOAD_LEN - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] SCALE_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    RELOAD = 1'b1
  } state_t;

  state_t          state;
  logic [RW-1:0]   rl_cnt;
  logic            ev_up;
  logic            ev_down;
  logic            ev_load;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] next_scale;

  scale_btn_path #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk_in (clk_in),
    .nrst   (nrst),
    .raw    (btn_up),
    .press  (ev_up)
  );

  scale_btn_path #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk_in (clk_in),
    .nrst   (nrst),
    .raw    (btn_down),
    .press  (ev_down)
  );

  scale_btn_path #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk_in (clk_in),
    .nrst   (nrst),
    .raw    (btn_load),
    .press  (ev_load)
  );

  // Step values stay WIDTH bits wide; the pinned cases are caught by an
  // explicit compare rather than a carry bit.
  always_comb begin
`ifdef SCALE_WRAP_EN
    up_val = scale + ONE;
    dn_val = scale - ONE;
`else
    up_val = (scale == SCALE_MAX) ? scale : scale + ONE;
    dn_val = (scale == '0)        ? scale : scale - ONE;
`endif
  end

  // Load beats up/down; simultaneous up and down cancel.
  always_comb begin
    next_scale = scale;
    if (ev_load) begin
      next_scale = load_val;
    end else if (ev_up && ev_down) begin
      next_scale = scale;
    end else if (ev_up) begin
      next_scale = up_val;
    end else if (ev_down) begin
      next_scale = dn_val;
    end
  end

  // Reset parks the FSM in RELOAD with the counter at 0, so the divider sees
  // SCALE_INIT under a full RELOAD_LEN pulse after nrst releases. Events are
  // only looked at in IDLE, which also keeps scale frozen during a reload.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state    <= RELOAD;
      rl_cnt   <= '0;
      scale    <= SCALE_INIT;
      div_nrst <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (next_scale != scale) begin
            scale    <= next_scale;
            state    <= RELOAD;
            rl_cnt   <= '0;
            div_nrst <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RELOAD: begin
          if (rl_cnt == RL_LAST) begin
            state    <= IDLE;
            rl_cnt   <= '0;
            div_nrst <= 1'b1;
            busy     <= 1'b0;
          end else begin
            rl_cnt <= rl_cnt + RW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scale_controller.sv
module tb_scale_controller;

  logic       clk_in = 1'b0;
  logic       nrst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_load;
  logic [7:0] load_val;
  logic [7:0] scale;
  logic       div_nrst;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       mon_en   = 1'b0;
  logic       prev_div = 1'b0;
  logic       in_pulse = 1'b0;
  int         low_len  = 0;
  logic [7:0] held     = 8'h00;
  logic       moved    = 1'b0;
  logic       found;

  always #5 clk_in = ~clk_in;

  scale_controller #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (16),
    .RELOAD_LEN      (4),
    .SCALE_INIT      (8'h00)
  ) dut (
    .clk_in   (clk_in),
    .nrst     (nrst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .load_val (load_val),
    .scale    (scale),
    .div_nrst (div_nrst),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every div_nrst fall must match a queued expected scale, last
  // exactly 4 cycles, and hold scale constant throughout.
  always @(negedge clk_in) begin
    if (!nrst || !mon_en) begin
      in_pulse = 1'b0;
      prev_div = div_nrst;
    end else begin
      if (prev_div && !div_nrst) begin
        check("reload_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("reload_scale", scale, exp_q.pop_front());
        check("busy_at_fall", busy, 1);
        in_pulse = 1'b1;
        low_len  = 1;
        held     = scale;
        moved    = 1'b0;
      end else if (!div_nrst && in_pulse) begin
        low_len++;
        if (scale !== held) moved = 1'b1;
      end else if (!prev_div && div_nrst && in_pulse) begin
        check("reload_len", low_len, 4);
        check("scale_frozen", moved, 0);
        check("busy_at_rise", busy, 0);
        in_pulse = 1'b0;
      end
      prev_div = div_nrst;
    end
  end

  task automatic press(input int which, input int hold);
    @(posedge clk_in); #1;
    case (which)
      0: btn_up   = 1'b1;
      1: btn_down = 1'b1;
      default: btn_load = 1'b1;
    endcase
    repeat (hold) @(posedge clk_in);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
    repeat (40) @(posedge clk_in);
    #1;
  endtask

  initial begin
    nrst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0; load_val = 8'h00;

    // Reset values and post-reset reload pulse
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_scale", scale, 8'h00);
    check("rst_div_nrst", div_nrst, 0);
    check("rst_busy", busy, 1);
    @(posedge clk_in); #1;
    nrst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      check("post_rst_low", div_nrst, 0);
    end
    @(posedge clk_in); @(negedge clk_in);
    check("post_rst_high", div_nrst, 1);
    check("post_rst_busy", busy, 0);
    mon_en = 1'b1;

    // Clean up press, exact latency
    @(posedge clk_in); #1;
    exp_q.push_back(8'h01);
    btn_up = 1'b1;
    repeat (19) @(posedge clk_in);
    @(negedge clk_in);
    check("up_before_e19_scale", scale, 8'h00);
    check("up_before_e19_div", div_nrst, 1);
    @(posedge clk_in); @(negedge clk_in);
    check("up_e19_scale", scale, 8'h01);
    check("up_e19_div", div_nrst, 0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("up_e22_div", div_nrst, 0);
    @(posedge clk_in); @(negedge clk_in);
    check("up_e23_div", div_nrst, 1);
    repeat (16) @(posedge clk_in);
    #1 btn_up = 1'b0;
    repeat (40) @(posedge clk_in);
    @(negedge clk_in);
    check("up_single_step", scale, 8'h01);

    // Bounce rejection
    @(posedge clk_in); #1 btn_up = 1'b1;
    repeat (10) @(posedge clk_in);
    #1 btn_up = 1'b0;
    repeat (5) @(posedge clk_in);
    #1 btn_up = 1'b1;
    repeat (10) @(posedge clk_in);
    #1 btn_up = 1'b0;
    repeat (40) @(posedge clk_in);
    @(negedge clk_in);
    check("bounce_scale", scale, 8'h01);

    // Bring scale to 0, then down at the floor
    load_val = 8'h00;
    exp_q.push_back(8'h00);
    press(2, 25);
    check("load_zero", scale, 8'h00);
`ifdef SCALE_WRAP_EN
    exp_q.push_back(8'hFF);
    press(1, 25);
    check("down_wrap", scale, 8'hFF);
`else
    press(1, 25);
    check("down_sat", scale, 8'h00);
`endif

    // Load FF, then up at the ceiling
    load_val = 8'hFF;
`ifndef SCALE_WRAP_EN
    exp_q.push_back(8'hFF);
`endif
    press(2, 25);
    check("load_ff", scale, 8'hFF);
`ifdef SCALE_WRAP_EN
    exp_q.push_back(8'h00);
    press(0, 25);
    check("up_wrap", scale, 8'h00);
`else
    press(0, 25);
    check("up_sat", scale, 8'hFF);
`endif

    // Load beats up; a down event landing inside the reload is dropped
    load_val = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk_in); #1;
    btn_load = 1'b1; btn_up = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 btn_down = 1'b1;
    repeat (25) @(posedge clk_in);
    #1;
    btn_load = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (40) @(posedge clk_in);
    @(negedge clk_in);
    check("prio_drop_scale", scale, 8'hA5);

    // Reset in the middle of a reload
    @(posedge clk_in); #1;
    exp_q.push_back(8'hA6);
    btn_up = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (div_nrst === 1'b0) found = 1'b1;
    end
    check("mid_reload_seen", found, 1);
    #2;
    nrst = 1'b0; btn_up = 1'b0;
    #1;
    check("abort_scale", scale, 8'h00);
    check("abort_div_nrst", div_nrst, 0);
    check("abort_busy", busy, 1);
    repeat (3) @(posedge clk_in);
    #1 nrst = 1'b1;
    repeat (10) @(posedge clk_in);
    @(negedge clk_in);
    check("after_abort_div", div_nrst, 1);
    check("after_abort_scale", scale, 8'h00);

    repeat (20) @(posedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
